// File: rtl/mem_port_arbiter.sv
// Single-ported SPRAM shared between instruction fetch and data ports.
// Data wins by default; a saturating streak counter forces a fetch grant so fetch cannot starve.
module mem_port_arbiter #(
  parameter int MEM_AW     = 14,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              core_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] LAST_NONE   = 2'd0;
  localparam logic [1:0] LAST_IFETCH = 2'd1;
  localparam logic [1:0] LAST_DREAD  = 2'd2;
  localparam logic [1:0] LAST_DERR   = 2'd3;
  localparam logic [3:0] STREAK_LIMIT = 4'(STREAK_MAX);

  logic [3:0]  streak_q, streak_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic        fetchWins;
  logic        dataInRange;
  logic        dataAccess;
  logic        unusedAddrBits;

  // Fetch ignores the upper address bits; byte-offset bits never reach the word-wide RAM.
  assign unusedAddrBits = ^{i_addr[31:MEM_AW+2], i_addr[1:0], d_addr[1:0]};

  always_comb begin
    dataInRange = (d_addr[31:MEM_AW+2] == '0);
    fetchWins   = i_req & (~d_req | (streak_q == STREAK_LIMIT));
    i_gnt       = resetb & fetchWins;
    d_gnt       = resetb & d_req & ~fetchWins;
    dataAccess  = d_gnt & dataInRange;
    core_stall  = (i_req & ~i_gnt) | (d_req & ~d_gnt);
    mem_en      = i_gnt | dataAccess;
    mem_we      = dataAccess & d_we;
    mem_be      = mem_we ? d_be : (mem_en ? 4'hF : 4'h0);
    mem_addr    = '0;
    mem_wdata   = '0;
    if (d_gnt) begin
      mem_addr  = d_addr[MEM_AW+1:2];
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr[MEM_AW+1:2];
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (i_gnt | ~i_req) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != STREAK_LIMIT)) begin
      streak_d = streak_q + 4'd1;
    end

    last_d = LAST_NONE;
    if (i_gnt) begin
      last_d = LAST_IFETCH;
    end else if (d_gnt & ~dataInRange) begin
      last_d = LAST_DERR;
    end else if (d_gnt & ~d_we) begin
      last_d = LAST_DREAD;
    end
  end

  // Read data bypasses straight from the RAM in the return cycle, then is held afterwards.
  always_comb begin
    i_rvalid = (last_q == LAST_IFETCH);
    d_rvalid = (last_q == LAST_DREAD);
    d_err    = (last_q == LAST_DERR);
    i_rdata  = i_rvalid ? mem_rdata : i_rdata_q;
    d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      streak_q  <= '0;
      last_q    <= LAST_NONE;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      streak_q  <= streak_d;
      last_q    <= last_d;
      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_mem_port_arbiter;

  localparam int MEM_AW     = 14;
  localparam int STREAK_MAX = 4;
  localparam int RAM_WORDS  = 1 << MEM_AW;

  localparam int K_NONE  = 0;
  localparam int K_FETCH = 1;
  localparam int K_READ  = 2;
  localparam int K_ERR   = 3;

  logic              clk = 1'b0;
  logic              resetb = 1'b0;
  logic              i_req = 1'b0;
  logic [31:0]       i_addr = '0;
  logic              i_gnt, i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [31:0]       d_addr = '0;
  logic [31:0]       d_wdata = '0;
  logic [3:0]        d_be = '0;
  logic              d_gnt, d_rvalid, d_err;
  logic [31:0]       d_rdata;
  logic              core_stall, mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  logic [31:0] ram    [RAM_WORDS];
  logic [31:0] refMem [RAM_WORDS];
  logic        modelIGnt = 1'b0;
  logic        modelDGnt = 1'b0;

  mem_port_arbiter #(.MEM_AW(MEM_AW), .STREAK_MAX(STREAK_MAX)) dut (
    .clk(clk), .resetb(resetb),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .core_stall(core_stall), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests just after the clock edge, then wait for the sampling point.
  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                               input logic [3:0] dbe);
    @(posedge clk); #1;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
    @(negedge clk);
  endtask

  // SPRAM stand-in, preloaded with each word's own index.
  initial begin
    for (int k = 0; k < RAM_WORDS; k++) ram[k] = k;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_rdata <= ram[mem_addr];
        end
      end
    end
  end

  // Reference model: who should win this cycle, and what should come back next cycle.
  initial begin
    int          pend;
    int          pendWord;
    int          fetchWaits;
    logic [31:0] expIR, expDR;
    logic        eI, eD, inRange, eEn;
    int          dWord, iWord;
    pend = K_NONE; pendWord = 0; fetchWaits = 0; expIR = '0; expDR = '0;
    for (int k = 0; k < RAM_WORDS; k++) refMem[k] = k;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        pend = K_NONE; expIR = '0; expDR = '0; fetchWaits = 0;
      end
      if (pend == K_FETCH) expIR = refMem[pendWord];
      if (pend == K_READ)  expDR = refMem[pendWord];
      checkOutput("i_rvalid", {31'd0, i_rvalid}, (pend == K_FETCH) ? 32'd1 : 32'd0);
      checkOutput("d_rvalid", {31'd0, d_rvalid}, (pend == K_READ)  ? 32'd1 : 32'd0);
      checkOutput("d_err",    {31'd0, d_err},    (pend == K_ERR)   ? 32'd1 : 32'd0);
      checkOutput("i_rdata", i_rdata, expIR);
      checkOutput("d_rdata", d_rdata, expDR);

      eI      = resetb && i_req && (!d_req || fetchWaits == STREAK_MAX);
      eD      = resetb && d_req && !eI;
      inRange = (d_addr >> (MEM_AW + 2)) == 32'd0;
      eEn     = eI || (eD && inRange);
      dWord   = int'((d_addr >> 2) % RAM_WORDS);
      iWord   = int'((i_addr >> 2) % RAM_WORDS);
      checkOutput("i_gnt",  {31'd0, i_gnt},  {31'd0, eI});
      checkOutput("d_gnt",  {31'd0, d_gnt},  {31'd0, eD});
      checkOutput("mem_en", {31'd0, mem_en}, {31'd0, eEn});
      checkOutput("core_stall", {31'd0, core_stall},
                  {31'd0, (i_req && !eI) || (d_req && !eD)});
      if (eEn) begin
        checkOutput("mem_we",   {31'd0, mem_we}, {31'd0, eD && d_we});
        checkOutput("mem_addr", {18'd0, mem_addr}, eD ? dWord : iWord);
        checkOutput("mem_be",   {28'd0, mem_be}, (eD && d_we) ? {28'd0, d_be} : 32'hF);
        if (eD && d_we) checkOutput("mem_wdata", mem_wdata, d_wdata);
      end

      if (eI)                pend = K_FETCH;
      else if (eD && !inRange) pend = K_ERR;
      else if (eD && !d_we)  pend = K_READ;
      else                   pend = K_NONE;
      pendWord = eI ? iWord : dWord;
      if (eD && inRange && d_we)
        for (int b = 0; b < 4; b++)
          if (d_be[b]) refMem[dWord][8*b +: 8] = d_wdata[8*b +: 8];
      if (!resetb || eI || !i_req) fetchWaits = 0;
      else if (eD && fetchWaits < STREAK_MAX) fetchWaits++;
      modelIGnt = eI;
      modelDGnt = eD;
    end
  end

  // Directed scenarios first, then randomized request traffic.
  initial begin
    logic [10:0] grantPattern;
    logic        expI;
    logic        iPend, dPend;

    repeat (3) @(posedge clk);
    #1 resetb = 1'b1;

    applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("seqGnt0", {31'd0, i_gnt}, 32'd1);
    checkOutput("seqStall", {31'd0, core_stall}, 32'd0);
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 0);
    checkOutput("seqData0", i_rdata, 32'd0);
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0);
    checkOutput("seqData1", i_rdata, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("seqValid2", {31'd0, i_rvalid}, 32'd1);
    checkOutput("seqData2", i_rdata, 32'd2);

    applyStimulus(1, 32'hC, 1, 0, 32'h100, 0, 0);
    checkOutput("bothDGnt", {31'd0, d_gnt}, 32'd1);
    checkOutput("bothStall", {31'd0, core_stall}, 32'd1);
    applyStimulus(1, 32'hC, 0, 0, 0, 0, 0);
    checkOutput("bothIGnt", {31'd0, i_gnt}, 32'd1);
    checkOutput("bothDData", d_rdata, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("bothIData", i_rdata, 32'h3);

    grantPattern = 11'b01000010000;
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1, 32'h40, 1, 0, 32'h200 + 32'(k) * 4, 0, 0);
      expI = grantPattern[k];
      checkOutput("streakIGnt", {31'd0, i_gnt}, {31'd0, expI});
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 0, 1, 1, 32'h20, 32'hDEADBEEF, 4'b0011);
    checkOutput("wrMemWe", {31'd0, mem_we}, 32'd1);
    checkOutput("wrMemBe", {28'd0, mem_be}, 32'h3);
    applyStimulus(0, 0, 1, 0, 32'h20, 0, 0);
    checkOutput("wrNoValid", {31'd0, d_rvalid}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rdMerged", d_rdata, 32'h0000BEEF);

    applyStimulus(0, 0, 1, 0, 32'h0001_0000, 0, 0);
    checkOutput("oorGnt", {31'd0, d_gnt}, 32'd1);
    checkOutput("oorMemEn", {31'd0, mem_en}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("oorErr", {31'd0, d_err}, 32'd1);
    checkOutput("oorNoValid", {31'd0, d_rvalid}, 32'd0);

    for (int k = 0; k < 3; k++)
      applyStimulus(1, 32'h44, 1, 0, 32'h300 + 32'(k) * 4, 0, 0);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; resetb = 1'b0;
    @(posedge clk); #1 resetb = 1'b1;
    @(negedge clk);
    checkOutput("rstIValid", {31'd0, i_rvalid}, 32'd0);
    checkOutput("rstDValid", {31'd0, d_rvalid}, 32'd0);
    checkOutput("rstIData", i_rdata, 32'd0);
    checkOutput("rstDData", d_rdata, 32'd0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 32'h48, 1, 0, 32'h400 + 32'(k) * 4, 0, 0);
      checkOutput("rstStreak", {31'd0, i_gnt}, (k == 4) ? 32'd1 : 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    iPend = 1'b0; dPend = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (modelIGnt) iPend = 1'b0;
      if (modelDGnt) dPend = 1'b0;
      if (!iPend) begin
        i_addr = $urandom;
        iPend  = ($urandom_range(0, 99) < 60);
      end
      if (!dPend) begin
        d_we    = $urandom_range(0, 1) == 1;
        d_wdata = $urandom;
        d_be    = 4'($urandom);
        d_addr  = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h0001_0000)
                                                : 32'($urandom_range(0, 255));
        dPend   = ($urandom_range(0, 99) < 70);
      end
      i_req = iPend;
      d_req = dPend;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
